// File: rtl/arm_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_decode_pkg
// Purpose  : Shared ARMv4 decode encodings: family indices, condition codes.
// Revision : 1.0
// ============================================================================
package arm_decode_pkg;

  localparam int FAM_W = 16;

  // Family index = bit position in the one-hot family vector.
  localparam logic [3:0] FAM_DP_IMMSH  = 4'd0;
  localparam logic [3:0] FAM_DP_REGSH  = 4'd1;
  localparam logic [3:0] FAM_DP_IMM    = 4'd2;
  localparam logic [3:0] FAM_MUL       = 4'd3;
  localparam logic [3:0] FAM_MULL      = 4'd4;
  localparam logic [3:0] FAM_SWP       = 4'd5;
  localparam logic [3:0] FAM_HALF      = 4'd6;
  localparam logic [3:0] FAM_LS_IMM    = 4'd7;
  localparam logic [3:0] FAM_LS_REG    = 4'd8;
  localparam logic [3:0] FAM_LSM       = 4'd9;
  localparam logic [3:0] FAM_BRANCH    = 4'd10;
  localparam logic [3:0] FAM_BX        = 4'd11;
  localparam logic [3:0] FAM_PSR       = 4'd12;
  localparam logic [3:0] FAM_SWI       = 4'd13;
  localparam logic [3:0] FAM_UNDEF     = 4'd14;
  localparam logic [3:0] FAM_COND_FAIL = 4'd15;

  typedef logic [FAM_W-1:0] fam_vec_t;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  function automatic fam_vec_t fam_onehot(input logic [3:0] idx);
    fam_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_cond_check.sv
`default_nettype none
// ============================================================================
// Module   : arm_cond_check
// Purpose  : Combinational ARMv4 condition-code evaluation against {N,Z,C,V}.
// Revision : 1.0
// ============================================================================
module arm_cond_check
  import arm_decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign {w_n, w_z, w_c, w_v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = w_z;
      NE: pass = !w_z;
      CS: pass = w_c;
      CC: pass = !w_c;
      MI: pass = w_n;
      PL: pass = !w_n;
      VS: pass = w_v;
      VC: pass = !w_v;
      HI: pass = w_c && !w_z;
      LS: pass = !w_c || w_z;
      GE: pass = (w_n == w_v);
      LT: pass = (w_n != w_v);
      GT: pass = !w_z && (w_n == w_v);
      LE: pass = w_z || (w_n != w_v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_family_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_family_decoder
// Purpose  : Two-stage (capture, classify) ARMv4 instruction family decoder.
//            IDEC_COND_EVAL_EN enables condition-fail (family 15) reporting.
// Revision : 1.0
// ============================================================================
module instr_family_decoder
  import arm_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [3:0]  nzcv,
  input  logic        flush,
  output logic [15:0] family_bits,
  output logic        fam_valid,
  input  logic        dec_take,
  output logic [31:0] instr_out,
  output logic        take_err
);

  // Priority-ordered classification; the first matching rule wins.
  function automatic fam_vec_t classify(input logic [31:0] w);
    logic [3:0] f;
    if (w[27:4] == 24'h12FFF1)
      f = FAM_BX;
    else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[11:4] == 8'h09)
      f = FAM_SWP;
    else if (w[27:22] == 6'b000000 && w[7:4] == 4'b1001)
      f = FAM_MUL;
    else if (w[27:23] == 5'b00001 && w[7:4] == 4'b1001)
      f = FAM_MULL;
    else if (w[27:25] == 3'b000 && w[7] && w[4])
      f = FAM_HALF;
    else if (w[27:26] == 2'b00 && w[24:23] == 2'b10 && !w[20])
      f = FAM_PSR;
    else if (w[27:25] == 3'b000 && w[4])
      f = FAM_DP_REGSH;
    else if (w[27:25] == 3'b000)
      f = FAM_DP_IMMSH;
    else if (w[27:25] == 3'b001)
      f = FAM_DP_IMM;
    else if (w[27:25] == 3'b010)
      f = FAM_LS_IMM;
    else if (w[27:25] == 3'b011 && !w[4])
      f = FAM_LS_REG;
    else if (w[27:25] == 3'b100)
      f = FAM_LSM;
    else if (w[27:25] == 3'b101)
      f = FAM_BRANCH;
    else if (w[27:24] == 4'b1111)
      f = FAM_SWI;
    else
      f = FAM_UNDEF;
    return fam_onehot(f);
  endfunction

  logic        r_s1_valid;
  logic [31:0] r_s1_instr;
  logic        r_s2_valid;
  fam_vec_t    r_s2_fam;
  logic [31:0] r_s2_instr;
  logic        r_take_err;

  logic        w_s1_adv;
  logic        w_in_ready;
  logic        w_accept;
  fam_vec_t    w_fam_sel;

  assign w_s1_adv   = !r_s2_valid || dec_take;
  assign w_in_ready = !flush && (!r_s1_valid || w_s1_adv);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= '0;
      r_s2_valid <= 1'b0;
      r_s2_fam   <= '0;
      r_s2_instr <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      // S2 is refilled from S1 (or left empty) whenever it is free or consumed.
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= r_s1_instr;
          r_s2_fam   <= classify(r_s1_instr);
        end
      end
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_instr <= in_instr;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_take_err <= 1'b0;
    else if (dec_take && !r_s2_valid)
      r_take_err <= 1'b1;
  end

`ifdef IDEC_COND_EVAL_EN
  logic w_cond_pass;

  // Live flags: a flag update by the previous instruction is seen immediately.
  arm_cond_check u_cond_check (
    .cond (r_s2_instr[31:28]),
    .nzcv (nzcv),
    .pass (w_cond_pass)
  );

  assign w_fam_sel = w_cond_pass ? r_s2_fam : fam_onehot(FAM_COND_FAIL);
`else
  logic w_unused_cond_pass;

  arm_cond_check u_cond_check (
    .cond (r_s2_instr[31:28]),
    .nzcv (nzcv),
    .pass (w_unused_cond_pass)
  );

  assign w_fam_sel = r_s2_fam;
`endif

  assign in_ready    = w_in_ready;
  assign fam_valid   = r_s2_valid;
  assign family_bits = r_s2_valid ? w_fam_sel : '0;
  assign instr_out   = r_s2_valid ? r_s2_instr : '0;
  assign take_err    = r_take_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_family_decoder.sv
`default_nettype none
// Self-checking bench for instr_family_decoder: directed vector table, hand
// sequences for handshake corners, and randomized traffic against a queue model.
module tb_instr_family_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [3:0]  nzcv = '0;
  logic        flush = 1'b0;
  logic        dec_take = 1'b0;
  logic        in_ready;
  logic [15:0] family_bits;
  logic        fam_valid;
  logic [31:0] instr_out;
  logic        take_err;

  instr_family_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .nzcv        (nzcv),
    .flush       (flush),
    .family_bits (family_bits),
    .fam_valid   (fam_valid),
    .dec_take    (dec_take),
    .instr_out   (instr_out),
    .take_err    (take_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] mask;
    logic [31:0] val;
    int          fam;
  } rule_t;
  rule_t rules[$];

  function automatic int ref_class(input logic [31:0] w);
    foreach (rules[i])
      if ((w & rules[i].mask) == rules[i].val) return rules[i].fam;
    return 14;
  endfunction

  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  function automatic logic [15:0] ref_family(input logic [31:0] w, input logic [3:0] f);
    logic [15:0] one;
    one = 16'h0001;
`ifdef IDEC_COND_EVAL_EN
    if (!ref_cond(w[31:28], f)) return 16'h8000;
`else
    if (ref_cond(w[31:28], f) && 1'b0) return 16'h8000;
`endif
    return one << ref_class(w);
  endfunction

  // Ordered queue of accepted words with the edge at which each was accepted.
  logic [31:0] mq_word[$];
  int          mq_at[$];
  int          edge_n = 0;
  bit          m_take_err = 1'b0;

  function automatic bit m_vis();
    return mq_word.size() > 0 && edge_n >= mq_at[0] + 1;
  endfunction

  function automatic bit m_ready();
    bit s1_full;
    s1_full = (mq_word.size() == 2) || (mq_word.size() == 1 && !m_vis());
    return !flush && (!s1_full || !m_vis() || dec_take);
  endfunction

  task automatic model_reset();
    mq_word.delete();
    mq_at.delete();
    edge_n     = 0;
    m_take_err = 1'b0;
  endtask

  task automatic model_edge();
    bit acc, take, vis;
    vis  = m_vis();
    acc  = in_valid && m_ready();
    take = vis && dec_take && !flush;
    if (dec_take && !vis) m_take_err = 1'b1;
    edge_n++;
    if (flush) begin
      mq_word.delete();
      mq_at.delete();
    end else begin
      if (take) begin
        void'(mq_word.pop_front());
        void'(mq_at.pop_front());
      end
      if (acc) begin
        mq_word.push_back(in_instr);
        mq_at.push_back(edge_n);
      end
    end
  endtask

  logic        s_rdy, s_fv, s_terr;
  logic [15:0] s_fam;
  logic [31:0] s_instr;

  task automatic check_outputs();
    bit vis;
    vis = m_vis();
    s_rdy = in_ready; s_fv = fam_valid; s_fam = family_bits;
    s_instr = instr_out; s_terr = take_err;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
    chk("fam_valid", {31'd0, fam_valid}, {31'd0, vis});
    chk("take_err", {31'd0, take_err}, {31'd0, m_take_err});
    chk("family_bits", {16'd0, family_bits},
        {16'd0, vis ? ref_family(mq_word[0], nzcv) : 16'h0000});
    if (vis) chk("instr_out", instr_out, mq_word[0]);
  endtask

  task automatic cycle(input bit v, input logic [31:0] w, input bit dt, input bit fl,
                       input logic [3:0] f);
    @(negedge clk);
    in_valid = v; in_instr = w; dec_take = dt; flush = fl; nzcv = f;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  logic [15:0] exp_cond_fail;
  logic [31:0] pool[$];

  initial begin
`ifdef IDEC_COND_EVAL_EN
    exp_cond_fail = 16'h8000;
`else
    exp_cond_fail = 16'h0001;
`endif
    rules.push_back('{32'h0FFFFFF0, 32'h012FFF10, 11});
    rules.push_back('{32'h0FB00FF0, 32'h01000090, 5});
    rules.push_back('{32'h0FC000F0, 32'h00000090, 3});
    rules.push_back('{32'h0F8000F0, 32'h00800090, 4});
    rules.push_back('{32'h0E000090, 32'h00000090, 6});
    rules.push_back('{32'h0D900000, 32'h01000000, 12});
    rules.push_back('{32'h0E000090, 32'h00000010, 1});
    rules.push_back('{32'h0E000010, 32'h00000000, 0});
    rules.push_back('{32'h0E000000, 32'h02000000, 2});
    rules.push_back('{32'h0E000000, 32'h04000000, 7});
    rules.push_back('{32'h0E000010, 32'h06000000, 8});
    rules.push_back('{32'h0E000000, 32'h08000000, 9});
    rules.push_back('{32'h0E000000, 32'h0A000000, 10});
    rules.push_back('{32'h0F000000, 32'h0F000000, 13});

    vecs.push_back('{32'hE0812003, 4'h0, 16'h0001});
    vecs.push_back('{32'hE0010392, 4'h0, 16'h0008});
    vecs.push_back('{32'hE12FFF1E, 4'h0, 16'h0800});
    vecs.push_back('{32'hE8BD8000, 4'h0, 16'h0200});
    vecs.push_back('{32'hEF000000, 4'h0, 16'h2000});
    vecs.push_back('{32'h00812003, 4'h0, exp_cond_fail});
    vecs.push_back('{32'h00812003, 4'h4, 16'h0001});
    vecs.push_back('{32'hE1C010B2, 4'h0, 16'h0040});
    vecs.push_back('{32'hE1A00110, 4'h0, 16'h0002});
    vecs.push_back('{32'hE3A00001, 4'h0, 16'h0004});
    vecs.push_back('{32'hE5901000, 4'h0, 16'h0080});
    vecs.push_back('{32'hE7901002, 4'h0, 16'h0100});
    vecs.push_back('{32'hE7901012, 4'h0, 16'h4000});
    vecs.push_back('{32'hEA000000, 4'h0, 16'h0400});
    vecs.push_back('{32'hE10F0000, 4'h0, 16'h1000});
    vecs.push_back('{32'hE1001091, 4'h0, 16'h0020});
    vecs.push_back('{32'hE0810392, 4'h0, 16'h0010});
    vecs.push_back('{32'hEE000000, 4'h0, 16'h4000});
    vecs.push_back('{32'hF0812003, 4'h0, exp_cond_fail});
    foreach (vecs[i]) pool.push_back(vecs[i].instr);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_fam_valid", {31'd0, fam_valid}, 32'd0);
    chk("rst_family_bits", {16'd0, family_bits}, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_take_err", {31'd0, take_err}, 32'd0);

    // Class sweep: word shows up two edges after acceptance
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].instr, 1'b0, 1'b0, vecs[i].flags);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, vecs[i].flags);
      chk("vec_latency_not_early", {31'd0, s_fv}, 32'd0);
      cycle(1'b0, 32'd0, 1'b1, 1'b0, vecs[i].flags);
      chk("vec_fam_valid", {31'd0, s_fv}, 32'd1);
      chk("vec_family", {16'd0, s_fam}, {16'd0, vecs[i].exp});
      chk("vec_instr", s_instr, vecs[i].instr);
    end

    // Flags change while held in S2
    cycle(1'b1, 32'h00812003, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h0);
    chk("flags_z0", {16'd0, s_fam}, {16'd0, exp_cond_fail});
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h4);
    chk("flags_z1", {16'd0, s_fam}, 32'h0001);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'h0);

    // Backpressure then three take pulses
    cycle(1'b1, 32'hE3A00001, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 32'hE5901000, 1'b0, 1'b0, 4'h0);
    chk("bp_ready_2nd", {31'd0, s_rdy}, 32'd1);
    cycle(1'b1, 32'hEA000000, 1'b0, 1'b0, 4'h0);
    chk("bp_ready_full", {31'd0, s_rdy}, 32'd0);
    cycle(1'b1, 32'hEA000000, 1'b1, 1'b0, 4'h0);
    chk("bp_order_1", s_instr, 32'hE3A00001);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h0);
    chk("bp_order_2", s_instr, 32'hE5901000);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h0);
    chk("bp_order_3", s_instr, 32'hEA000000);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h0);
    chk("bp_drained", {31'd0, s_fv}, 32'd0);

    // Flush with both stages full and a word offered
    cycle(1'b1, 32'hE0812003, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 32'hE0010392, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 32'hEF000000, 1'b1, 1'b1, 4'h0);
    chk("flush_ready_low", {31'd0, s_rdy}, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h0);
    chk("flush_fam_valid", {31'd0, s_fv}, 32'd0);
    chk("flush_family", {16'd0, s_fam}, 32'd0);
    chk("flush_ready", {31'd0, s_rdy}, 32'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'h0);
    chk("flush_not_captured", {31'd0, s_fv}, 32'd0);

    // Stray take sets the sticky error
    chk("terr_clean", {31'd0, s_terr}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 4'h0);
    cycle(1'b1, 32'hE12FFF1E, 1'b0, 1'b0, 4'h0);
    chk("terr_set", {31'd0, s_terr}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = ($urandom_range(1) == 0) ? $urandom() : pool[$urandom_range(pool.size() - 1)];
      if ($urandom_range(3) == 0) w[31:28] = 4'($urandom_range(15));
      cycle($urandom_range(3) != 0, w, $urandom_range(1) == 1,
            $urandom_range(15) == 0, 4'($urandom_range(15)));
    end
    chk("terr_sticky", {31'd0, s_terr}, 32'd1);

    // Async reset mid-transfer
    cycle(1'b1, 32'hE0812003, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 32'hE8BD8000, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE3A00001; dec_take = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fam_valid", {31'd0, fam_valid}, 32'd0);
    chk("arst_family", {16'd0, family_bits}, 32'd0);
    chk("arst_instr", instr_out, 32'd0);
    chk("arst_take_err", {31'd0, take_err}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 200; i++) begin
      cycle($urandom_range(1) == 1, pool[$urandom_range(pool.size() - 1)],
            $urandom_range(1) == 1, $urandom_range(31) == 0, 4'($urandom_range(15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_family_decoder.md
# instr_family_decoder

Front end of the ARMv4 microsequencer. Accepts 32-bit instructions from fetch over a valid/ready handshake and classifies each into one of 16 one-hot instruction families. The sequencer's decode dispatch consumes the family vector on its DEC cycle. Includes a two-stage buffer (capture, classify), flush, and condition-code evaluation.

## Interface
- No parameters; family encoding is fixed by the shared package.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  decoder accepts in_instr this cycle
- in_instr  in  32  ARMv4 instruction word
- nzcv  in  4  current CPSR flags {N,Z,C,V}
- flush  in  1  synchronous pipeline clear (taken branch / exception)
- family_bits  out  16  one-hot family to the sequencer; all zero when fam_valid=0
- fam_valid  out  1  family_bits/instr_out hold a decoded instruction
- dec_take  in  1  sequencer consumes the current family (DEC microinstruction)
- instr_out  out  32  instruction word matching family_bits (IR load)
- take_err  out  1  sticky: dec_take seen while fam_valid=0

## Operation
- S1 (capture): holds the raw word. S2 (classify): holds the registered one-hot class plus the word.
- Classification priority, first match wins; family index = bit set:
  - 11 BX: [27:4]=0x12FFF1.
  - 5 SWP: [27:23]=00010, [21:20]=00, [11:4]=0x09.
  - 3 MUL/MLA: [27:22]=0, [7:4]=1001.
  - 4 long multiply: [27:23]=00001, [7:4]=1001.
  - 6 halfword/signed transfer: [27:25]=000, [7]=1, [4]=1.
  - 12 MRS/MSR: [27:26]=00, [24:23]=10, [20]=0.
  - 1 DP shift-by-register: [27:25]=000, [7]=0, [4]=1.
  - 0 DP shift-by-immediate: [27:25]=000, [4]=0.
  - 2 DP immediate: [27:25]=001.
  - 7 LDR/STR imm: 010.
  - 8 LDR/STR reg: 011 with [4]=0.
  - 9 LDM/STM: 100.
  - 10 B/BL: 101.
  - 13 SWI: [27:24]=1111.
  - 14 undefined: everything else, including coprocessor space and 011 with [4]=1.
- Condition: family_bits = bit 15 (16'h8000) when cond check fails. The check is evaluated combinationally from S2's cond field and the live nzcv, so flags written by the preceding instruction are honoured. cond=1111 (NV) always fails.
- Output: family_bits is exactly one-hot while fam_valid=1.

## Timing
- Reset values: fam_valid=0, family_bits=0, instr_out=0, take_err=0, S1/S2 empty. in_ready=1 in the first cycle after reset.
- in_ready = !flush && (!s1_valid || s1 advances this cycle).
- S1 advances when !s2_valid || dec_take.
- Latency: word accepted at edge N is in S1 after N, and appears with fam_valid=1 after N+1. Sustained throughput is 1 per cycle when dec_take is held high.
- Backpressure: with dec_take low, two words are accepted, then in_ready=0. Order is preserved and no word is lost or duplicated.
- dec_take with fam_valid=1: S2 is freed at that edge. S1 (or nothing) refills it at the same edge.
- flush: at the next edge both stages empty and fam_valid=0. A same-cycle dec_take has no effect. No word is accepted that cycle.
- Async reset mid-transfer: all state is cleared immediately and outputs return to reset values.
- dec_take while fam_valid=0: ignored for data and sets take_err. take_err stays set until reset.

## Configuration
- IDEC_COND_EVAL_EN defined: condition evaluation as above, producing family 15 on failure.
- Not defined: the cond field is ignored, bit 15 is never produced, and nzcv is unused. This mode is for bring-up of the sequencer without flag logic.

## Structure
- Package arm_decode_pkg holds:
  - family index localparams FAM_DP_IMMSH … FAM_COND_FAIL (0–15),
  - the condition-code enum (EQ…NV),
  - the family width (16).
- Sub-module arm_cond_check takes cond[3:0] and nzcv[3:0] and outputs pass (combinational). The same block is reused by the execute stage.
- Classifier is a combinational function in the top module. S1/S2 registers and the handshake also live in the top module.

## Test plan
- Class sweep, AL, dec_take=1:
  - E0812003 → 16'h0001
  - E0010392 → 16'h0008
  - E12FFF1E → 16'h0800
  - E8BD8000 → 16'h0200
  - EF000000 → 16'h2000
  - Each appears 2 cycles after acceptance; instr_out matches.
- Condition: 00812003 (ADDEQ) with nzcv=4'b0000 → 16'h8000. Same word with nzcv=4'b0100 → 16'h0001. Flags change while the word is held in S2 → family_bits follows the same cycle.
- Backpressure: in_valid high for 3 words, dec_take=0 → in_ready=0 after the 2nd. Then 3 single-cycle dec_take pulses → words emerge in order with no gaps beyond handshake.
- Flush with S1 and S2 full and in_valid=1 → next cycle fam_valid=0, family_bits=0, in_ready=1, and the offered word is not captured.
- dec_take pulse with fam_valid=0 → take_err=1 and remains 1 through later traffic. rst_n low → take_err=0 immediately.
- Without IDEC_COND_EVAL_EN: 00812003 with nzcv=0 → 16'h0001.
